// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - UART framed command parser driving audio FIFO, NCO carrier and RF gate
// Frame: A5, CMD, D0..D3 (little-endian), CHK = CMD^D0^D1^D2^D3.
module uart_cmd_ctrl #(
  parameter logic [31:0] DEFAULT_CARRIER = 32'd609885356,
  parameter logic [24:0] DEFAULT_HANG    = 25'd20_000_000,
  parameter logic [19:0] FRAME_TIMEOUT   = 20'd100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        fifo_full,
  input  logic        fifo_empty,
  output logic [31:0] fifo_din,
  output logic        fifo_wr_en,
  output logic [31:0] carrier_inc,
  output logic        tx_enable,
  output logic        cmd_err,
  output logic [7:0]  ovf_cnt
);

  typedef enum logic [1:0] {S_HUNT, S_CMD, S_DATA, S_CHK} state_t;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam logic [7:0] CMD_AUDIO   = 8'h01;
  localparam logic [7:0] CMD_CARRIER = 8'h02;
  localparam logic [7:0] CMD_HANG    = 8'h03;
  localparam logic [7:0] CMD_PTT     = 8'h04;

  localparam logic [1:0] MODE_VOX = 2'd0;
  localparam logic [1:0] MODE_ON  = 2'd1;
  localparam logic [1:0] MODE_OFF = 2'd2;

  state_t      state, state_next;
  logic [1:0]  idx;
  logic [7:0]  cmd_reg;
  logic [31:0] payload;
  logic [19:0] gap_cnt;
  logic [24:0] hang_reg;
  logic [24:0] hang_cnt;
  logic [1:0]  mode;

  logic [7:0]  chk_calc;
  logic        cmd_known;
  logic        exec;
  logic        reject;
  logic        timeout;

  assign chk_calc = cmd_reg ^ payload[7:0] ^ payload[15:8] ^ payload[23:16] ^ payload[31:24];

  always_comb begin
    cmd_known = 1'b0;
    case (cmd_reg)
      CMD_AUDIO, CMD_CARRIER, CMD_HANG: cmd_known = 1'b1;
      CMD_PTT:                          cmd_known = (payload[1:0] != 2'd3);
      default:                          cmd_known = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_HUNT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    exec       = 1'b0;
    reject     = 1'b0;
    timeout    = 1'b0;
    case (state)
      S_HUNT: if (rx_valid && rx_data == SYNC_BYTE) state_next = S_CMD;
      S_CMD:  if (rx_valid) state_next = S_DATA;
      S_DATA: if (rx_valid && idx == 2'd3) state_next = S_CHK;
      S_CHK: begin
        if (rx_valid) begin
          state_next = S_HUNT;
          if (rx_data == chk_calc && cmd_known) exec = 1'b1;
          else                                  reject = 1'b1;
        end
      end
      default: state_next = S_HUNT;
    endcase
    // A byte arriving on the timeout cycle keeps the frame alive.
    if (state != S_HUNT && !rx_valid && gap_cnt == FRAME_TIMEOUT) begin
      state_next = S_HUNT;
      timeout    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt <= '0;
    end else if (state == S_HUNT || rx_valid || timeout) begin
      gap_cnt <= '0;
    end else begin
      gap_cnt <= gap_cnt + 20'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      cmd_reg <= '0;
      payload <= '0;
    end else if (rx_valid) begin
      case (state)
        S_CMD: begin
          cmd_reg <= rx_data;
          idx     <= 2'd0;
        end
        S_DATA: begin
          case (idx)
            2'd0:    payload[7:0]   <= rx_data;
            2'd1:    payload[15:8]  <= rx_data;
            2'd2:    payload[23:16] <= rx_data;
            default: payload[31:24] <= rx_data;
          endcase
          idx <= idx + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_din    <= '0;
      fifo_wr_en  <= 1'b0;
      carrier_inc <= DEFAULT_CARRIER;
      hang_reg    <= DEFAULT_HANG;
      mode        <= MODE_VOX;
      cmd_err     <= 1'b0;
      ovf_cnt     <= '0;
    end else begin
      fifo_wr_en <= 1'b0;
      cmd_err    <= reject | timeout;
      if (exec) begin
        case (cmd_reg)
          CMD_AUDIO: begin
            if (fifo_full) begin
              if (ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
            end else begin
              fifo_din   <= payload;
              fifo_wr_en <= 1'b1;
            end
          end
          CMD_CARRIER: carrier_inc <= payload;
          CMD_HANG:    hang_reg    <= payload[24:0];
          CMD_PTT:     mode        <= payload[1:0];
          default: ;
        endcase
      end
    end
  end

  // hang_reg is sampled only on reload, so a new value never disturbs a running countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hang_cnt  <= '0;
      tx_enable <= 1'b0;
    end else begin
      case (mode)
        MODE_ON: begin
          hang_cnt  <= '0;
          tx_enable <= 1'b1;
        end
        MODE_OFF: begin
          hang_cnt  <= '0;
          tx_enable <= 1'b0;
        end
        default: begin
          if (!fifo_empty) begin
            hang_cnt  <= hang_reg;
            tx_enable <= 1'b1;
          end else begin
            tx_enable <= (hang_cnt != '0);
            if (hang_cnt != '0) hang_cnt <= hang_cnt - 25'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - directed self-checking bench for uart_cmd_ctrl
// A short FRAME_TIMEOUT keeps the idle-gap scenarios brief.
module tb_uart_cmd_ctrl;

  localparam logic [31:0] DCAR = 32'd609885356;
  localparam logic [24:0] DHANG = 25'd3;
  localparam int          TO = 200;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        fifo_full;
  logic        fifo_empty;
  logic [31:0] fifo_din;
  logic        fifo_wr_en;
  logic [31:0] carrier_inc;
  logic        tx_enable;
  logic        cmd_err;
  logic [7:0]  ovf_cnt;

  int checks = 0;
  int errors = 0;
  int err_cnt = 0;
  int wr_cnt = 0;
  int cyc = 0;

  uart_cmd_ctrl #(
    .DEFAULT_CARRIER(DCAR),
    .DEFAULT_HANG(DHANG),
    .FRAME_TIMEOUT(20'(TO))
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .fifo_full(fifo_full),
    .fifo_empty(fifo_empty),
    .fifo_din(fifo_din),
    .fifo_wr_en(fifo_wr_en),
    .carrier_inc(carrier_inc),
    .tx_enable(tx_enable),
    .cmd_err(cmd_err),
    .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (cmd_err) err_cnt <= err_cnt + 1;
    if (fifo_wr_en) wr_cnt <= wr_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    step();
    rx_data = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3, input logic [7:0] k);
    send_byte(8'hA5);
    send_byte(c);
    send_byte(d0);
    send_byte(d1);
    send_byte(d2);
    send_byte(d3);
    send_byte(k);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; fifo_full = 1'b0; fifo_empty = 1'b1;
    repeat (3) step();
    checks++; if (carrier_inc !== DCAR) begin errors++; $display("FAIL reset_carrier got %h exp %h", carrier_inc, DCAR); end
    checks++; if ({fifo_wr_en, tx_enable, cmd_err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {fifo_wr_en, tx_enable, cmd_err}); end
    checks++; if (fifo_din !== 32'h0 || ovf_cnt !== 8'h0) begin errors++; $display("FAIL reset_din_ovf got %h/%h exp 0/0", fifo_din, ovf_cnt); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_carrier();
    int e0 = err_cnt;
    send_frame(8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'h0A);
    checks++; if (carrier_inc !== 32'h12345678) begin errors++; $display("FAIL carrier_set got %h exp 12345678", carrier_inc); end
    checks++; if (err_cnt != e0) begin errors++; $display("FAIL carrier_no_err got %0d exp %0d", err_cnt, e0); end
  endtask

  task automatic test_audio();
    int w0 = wr_cnt;
    send_frame(8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45);
    checks++; if (fifo_wr_en !== 1'b1 || fifo_din !== 32'h44332211) begin errors++; $display("FAIL audio_write got %b/%h exp 1/44332211", fifo_wr_en, fifo_din); end
    step();
    checks++; if (wr_cnt != w0 + 1) begin errors++; $display("FAIL audio_one_pulse got %0d exp %0d", wr_cnt - w0, 1); end
    fifo_full = 1'b1;
    send_frame(8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45);
    step();
    checks++; if (wr_cnt != w0 + 1) begin errors++; $display("FAIL audio_full_suppress got %0d exp %0d", wr_cnt - w0, 1); end
    checks++; if (ovf_cnt !== 8'd1) begin errors++; $display("FAIL audio_ovf got %0d exp 1", ovf_cnt); end
  endtask

  task automatic test_ovf_saturate();
    for (int i = 0; i < 253; i++) send_frame(8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01);
    checks++; if (ovf_cnt !== 8'd254) begin errors++; $display("FAIL ovf_254 got %0d exp 254", ovf_cnt); end
    send_frame(8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01);
    send_frame(8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01);
    checks++; if (ovf_cnt !== 8'd255) begin errors++; $display("FAIL ovf_saturate got %0d exp 255", ovf_cnt); end
    fifo_full = 1'b0;
  endtask

  task automatic test_bad_frames();
    int e0 = err_cnt;
    send_frame(8'h02, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00);
    checks++; if (cmd_err !== 1'b1) begin errors++; $display("FAIL badchk_pulse got %b exp 1", cmd_err); end
    checks++; if (carrier_inc !== 32'h12345678) begin errors++; $display("FAIL badchk_carrier got %h exp 12345678", carrier_inc); end
    send_frame(8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h07);
    step();
    checks++; if (err_cnt != e0 + 2) begin errors++; $display("FAIL bad_err_count got %0d exp %0d", err_cnt - e0, 2); end
  endtask

  task automatic test_timeout();
    int e0;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h78);
    e0 = err_cnt;
    repeat (TO) step();
    checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL timeout_early got %b exp 0", cmd_err); end
    step();
    checks++; if (cmd_err !== 1'b1) begin errors++; $display("FAIL timeout_pulse got %b exp 1", cmd_err); end
    step();
    checks++; if (err_cnt != e0 + 1) begin errors++; $display("FAIL timeout_count got %0d exp 1", err_cnt - e0); end
    send_frame(8'h02, 8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'hCB);
    checks++; if (carrier_inc !== 32'hCAFEF00D) begin errors++; $display("FAIL timeout_recover got %h exp cafef00d", carrier_inc); end
  endtask

  task automatic test_timeout_boundary();
    int e0 = err_cnt;
    send_byte(8'hA5);
    repeat (TO - 1) step();
    send_byte(8'h02);
    checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL boundary_err got %b exp 0", cmd_err); end
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12); send_byte(8'h0A);
    checks++; if (carrier_inc !== 32'h12345678 || err_cnt != e0) begin errors++; $display("FAIL boundary_frame got %h/%0d exp 12345678/0", carrier_inc, err_cnt - e0); end
  endtask

  task automatic test_hang();
    logic [7:0] hv [2] = '{8'd10, 8'd0};
    int         ex [2] = '{11, 1};
    int n;
    for (int i = 0; i < 2; i++) begin
      send_frame(8'h03, hv[i], 8'h00, 8'h00, 8'h00, 8'h03 ^ hv[i]);
      fifo_empty = 1'b0;
      repeat (5) step();
      checks++; if (tx_enable !== 1'b1) begin errors++; $display("FAIL hang_on_%0d got %b exp 1", i, tx_enable); end
      fifo_empty = 1'b1;
      n = 0;
      while (tx_enable && n < 100) begin step(); n++; end
      checks++; if (n != ex[i]) begin errors++; $display("FAIL hang_len_%0d got %0d exp %0d", i, n, ex[i]); end
    end
  endtask

  task automatic test_hang_update();
    int c0;
    int n;
    send_frame(8'h03, 8'h28, 8'h00, 8'h00, 8'h00, 8'h2B);
    fifo_empty = 1'b0;
    repeat (2) step();
    fifo_empty = 1'b1;
    c0 = cyc;
    send_frame(8'h03, 8'h05, 8'h00, 8'h00, 8'h00, 8'h06);
    n = 0;
    while (tx_enable && n < 200) begin step(); n++; end
    checks++; if (cyc - c0 != 41) begin errors++; $display("FAIL hang_running got %0d exp 41", cyc - c0); end
    fifo_empty = 1'b0;
    repeat (2) step();
    fifo_empty = 1'b1;
    n = 0;
    while (tx_enable && n < 100) begin step(); n++; end
    checks++; if (n != 6) begin errors++; $display("FAIL hang_reload got %0d exp 6", n); end
  endtask

  task automatic test_ptt();
    send_frame(8'h04, 8'h01, 8'h00, 8'h00, 8'h00, 8'h05);
    repeat (3) step();
    checks++; if (tx_enable !== 1'b1) begin errors++; $display("FAIL ptt_on got %b exp 1", tx_enable); end
    fifo_empty = 1'b0;
    send_frame(8'h04, 8'h02, 8'h00, 8'h00, 8'h00, 8'h06);
    repeat (3) step();
    checks++; if (tx_enable !== 1'b0) begin errors++; $display("FAIL ptt_off got %b exp 0", tx_enable); end
    send_frame(8'h04, 8'h03, 8'h00, 8'h00, 8'h00, 8'h07);
    checks++; if (cmd_err !== 1'b1) begin errors++; $display("FAIL ptt_reserved_err got %b exp 1", cmd_err); end
    repeat (3) step();
    checks++; if (tx_enable !== 1'b0) begin errors++; $display("FAIL ptt_reserved_mode got %b exp 0", tx_enable); end
    send_frame(8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04);
    repeat (2) step();
    checks++; if (tx_enable !== 1'b1) begin errors++; $display("FAIL ptt_vox got %b exp 1", tx_enable); end
  endtask

  task automatic test_reset_midframe();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h78);
    rst_n = 1'b0;
    #1;
    checks++; if (carrier_inc !== DCAR || tx_enable !== 1'b0 || ovf_cnt !== 8'd0) begin errors++; $display("FAIL midframe_reset got %h/%b/%0d exp %h/0/0", carrier_inc, tx_enable, ovf_cnt, DCAR); end
    step();
    rst_n = 1'b1;
    step();
    send_frame(8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'h0A);
    checks++; if (carrier_inc !== 32'h12345678) begin errors++; $display("FAIL midframe_recover got %h exp 12345678", carrier_inc); end
  endtask

  initial begin
    test_reset();
    test_carrier();
    test_audio();
    test_ovf_saturate();
    test_bad_frames();
    test_timeout();
    test_timeout_boundary();
    test_hang();
    test_hang_update();
    test_ptt();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
